uart_block_bridge: RTL and testbench

Byte-stream to block bridge between a UART receiver/transmitter pair and a block-processing core (e.g. AES encryption).
- Collects BLOCK_BYTES received bytes into one block and hands it to the core over a valid/ready handshake.
- Accepts the core's result block and serialises it back out one byte at a time, with a programmable inter-byte gap.
- Adds a partial-block timeout, overrun reporting and a selectable auto/manual transmit mode.

---
 rtl/uart_bridge_pkg.sv | 15 +
 rtl/uart_block_bridge_serializer.sv | 96 +++++++++
 rtl/uart_block_bridge.sv | 125 ++++++++++++
 tb/tb_uart_block_bridge.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_bridge_pkg.sv
// Shared types, default sizing and width helper for the UART <-> block bridge.
package uart_bridge_pkg;

    localparam int DEF_BLOCK_BYTES = 16;
    localparam int DEF_GAP_CYCLES  = 100000;

    typedef enum logic {COLLECT, HAND} rx_state_t;
    typedef enum logic [1:0] {IDLE, ARMED, SEND, GAP} tx_state_t;

    // Bits needed to hold 0..max_val; never less than one bit so disabled counters still elaborate.
    function automatic int width_of(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/uart_block_bridge_serializer.sv
// block_serializer: latches a result block and emits it MSB byte first, with an
// optional inter-byte gap and auto/manual start.
module block_serializer
    import uart_bridge_pkg::*;
#(
    parameter int BLOCK_BYTES = DEF_BLOCK_BYTES,
    parameter int GAP_CYCLES  = DEF_GAP_CYCLES,
    parameter int AUTO_TX     = 0
)(
    input  logic                       clock,
    input  logic                       reset,
    input  logic [8*BLOCK_BYTES-1:0]   blk_in_data,
    input  logic                       blk_in_valid,
    output logic                       blk_in_ready,
    input  logic                       tx_start,
    output logic                       tx_dv,
    output logic [7:0]                 tx_byte,
    input  logic                       tx_done,
    output logic                       tx_busy
);

    localparam int BW = 8 * BLOCK_BYTES;
    localparam int CW = width_of(BLOCK_BYTES);
    localparam int GW = width_of(GAP_CYCLES);
    localparam logic [CW-1:0] IDX_LAST = CW'(BLOCK_BYTES - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [GW-1:0] GAP_MAX  = GW'(GAP_CYCLES);

    tx_state_t       r_state;
    tx_state_t       w_next;
    logic [BW-1:0]   r_latch;
    logic [7:0]      r_byte;
    logic [CW-1:0]   r_idx;
    logic [GW-1:0]   r_gap;
    logic            r_dv;
    logic            w_enter_send;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // Auto mode still passes through ARMED for one cycle, giving the
    // two-cycle valid-to-tx_dv latency; tx_start only matters in ARMED.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:  if (blk_in_valid) w_next = ARMED;
            ARMED: if ((AUTO_TX != 0) || tx_start) w_next = SEND;
            SEND: begin
                if (tx_done) begin
                    if (r_idx == IDX_LAST)    w_next = IDLE;
                    else if (GAP_CYCLES == 0) w_next = SEND;
                    else                      w_next = GAP;
                end
            end
            GAP:   if (r_gap == GAP_LAST) w_next = SEND;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        blk_in_ready = (r_state == IDLE);
        tx_busy      = (r_state != IDLE);
    end

    // Any transition into SEND (including SEND->SEND when the gap is zero) launches a byte.
    assign w_enter_send = (w_next == SEND) && ((r_state != SEND) || tx_done);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_latch <= '0;
            r_byte  <= '0;
            r_idx   <= '0;
            r_gap   <= '0;
            r_dv    <= 1'b0;
        end else begin
            r_dv <= w_enter_send;
            if ((r_state == IDLE) && blk_in_valid) begin
                r_latch <= blk_in_data;
                r_idx   <= '0;
            end
            if (w_enter_send) begin
                r_byte  <= r_latch[BW-1:BW-8];
                r_latch <= {r_latch[BW-9:0], 8'h00};
                if (r_state != ARMED) r_idx <= r_idx + CW'(1);
            end
            if (r_state == SEND)                           r_gap <= '0;
            else if ((r_state == GAP) && (r_gap != GAP_MAX)) r_gap <= r_gap + GW'(1);
        end
    end

    assign tx_dv   = r_dv;
    assign tx_byte = r_byte;

endmodule

// File: rtl/uart_block_bridge.sv
// Byte-stream to block bridge: assembles received bytes into blocks for the core
// and hands core results to block_serializer for transmission.
module uart_block_bridge
    import uart_bridge_pkg::*;
#(
    parameter int BLOCK_BYTES    = DEF_BLOCK_BYTES,
    parameter int GAP_CYCLES     = DEF_GAP_CYCLES,
    parameter int TIMEOUT_CYCLES = 0,
    parameter int AUTO_TX        = 0
)(
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic                                 rx_valid,
    input  logic [7:0]                           rx_byte,
    output logic [8*BLOCK_BYTES-1:0]             blk_out_data,
    output logic                                 blk_out_valid,
    input  logic                                 blk_out_ready,
    input  logic [8*BLOCK_BYTES-1:0]             blk_in_data,
    input  logic                                 blk_in_valid,
    output logic                                 blk_in_ready,
    input  logic                                 tx_start,
    output logic                                 tx_dv,
    output logic [7:0]                           tx_byte,
    input  logic                                 tx_done,
    output logic [width_of(BLOCK_BYTES)-1:0]     rx_count,
    output logic                                 rx_overrun,
    output logic                                 rx_timeout,
    output logic                                 tx_busy
);

    localparam int BW = 8 * BLOCK_BYTES;
    localparam int CW = width_of(BLOCK_BYTES);
    localparam int TW = width_of(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(BLOCK_BYTES - 1);
    localparam logic [TW-1:0] SIL_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [TW-1:0] SIL_MAX  = TW'(TIMEOUT_CYCLES);

    rx_state_t       r_rx_state;
    rx_state_t       w_rx_next;
    logic [BW-1:0]   r_shift;
    logic [CW-1:0]   r_count;
    logic [TW-1:0]   r_sil;
    logic            r_overrun;
    logic            r_timeout;
    logic            w_expire;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_rx_state <= COLLECT;
        else       r_rx_state <= w_rx_next;
    end

    always_comb begin
        w_rx_next = r_rx_state;
        case (r_rx_state)
            COLLECT: if (rx_valid && (r_count == CNT_LAST)) w_rx_next = HAND;
            HAND:    if (blk_out_ready) w_rx_next = COLLECT;
            default: w_rx_next = COLLECT;
        endcase
    end

    always_comb begin
        blk_out_valid = (r_rx_state == HAND);
    end

    // Expiry lands on the TIMEOUT_CYCLES-th edge after the last byte; a byte in that cycle wins.
    assign w_expire = (TIMEOUT_CYCLES > 0) && (r_rx_state == COLLECT) &&
                      (r_count != '0) && (r_sil == SIL_LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset)                          r_sil <= '0;
        else if (rx_valid || (r_count == '0)) r_sil <= '0;
        else if (r_sil != SIL_MAX)          r_sil <= r_sil + TW'(1);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_shift   <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            r_timeout <= 1'b0;
            if (r_rx_state == COLLECT) begin
                if (rx_valid) begin
                    r_shift <= {r_shift[BW-9:0], rx_byte};
                    r_count <= r_count + CW'(1);
                end else if (w_expire) begin
                    r_shift   <= '0;
                    r_count   <= '0;
                    r_timeout <= 1'b1;
                end
            end else if (blk_out_ready) begin
                // A byte arriving with the accepting ready starts the next block.
                if (rx_valid) r_shift <= {{(BW-8){1'b0}}, rx_byte};
                r_count <= rx_valid ? CW'(1) : '0;
            end else if (rx_valid) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign blk_out_data = r_shift;
    assign rx_count     = r_count;
    assign rx_overrun   = r_overrun;
    assign rx_timeout   = r_timeout;

    block_serializer #(
        .BLOCK_BYTES (BLOCK_BYTES),
        .GAP_CYCLES  (GAP_CYCLES),
        .AUTO_TX     (AUTO_TX)
    ) u_ser (
        .clock        (clock),
        .reset        (reset),
        .blk_in_data  (blk_in_data),
        .blk_in_valid (blk_in_valid),
        .blk_in_ready (blk_in_ready),
        .tx_start     (tx_start),
        .tx_dv        (tx_dv),
        .tx_byte      (tx_byte),
        .tx_done      (tx_done),
        .tx_busy      (tx_busy)
    );

endmodule

// File: tb/tb_uart_block_bridge.sv
// Directed bench: manual-start bridge with gap/timeout (A) and auto-start back-to-back bridge (B).
module tb_uart_block_bridge;

    localparam int BB = 4;
    localparam int BW = 8 * BB;
    localparam int CW = 3;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic          a_rx_valid = 1'b0, b_rx_valid = 1'b0;
    logic [7:0]    a_rx_byte = '0, b_rx_byte = '0;
    logic [BW-1:0] a_blk_out_data, b_blk_out_data;
    logic          a_blk_out_valid, b_blk_out_valid;
    logic          a_blk_out_ready = 1'b0, b_blk_out_ready = 1'b0;
    logic [BW-1:0] a_blk_in_data = '0, b_blk_in_data = '0;
    logic          a_blk_in_valid = 1'b0, b_blk_in_valid = 1'b0;
    logic          a_blk_in_ready, b_blk_in_ready;
    logic          a_tx_start = 1'b0, b_tx_start = 1'b0;
    logic          a_tx_dv, b_tx_dv;
    logic [7:0]    a_tx_byte, b_tx_byte;
    logic          a_tx_done = 1'b0, b_tx_done = 1'b0;
    logic [CW-1:0] a_rx_count, b_rx_count;
    logic          a_rx_overrun, b_rx_overrun, a_rx_timeout, b_rx_timeout;
    logic          a_tx_busy, b_tx_busy;

    uart_block_bridge #(.BLOCK_BYTES(BB), .GAP_CYCLES(5), .TIMEOUT_CYCLES(50), .AUTO_TX(0)) dut_a (
        .clock(clock), .reset(reset), .rx_valid(a_rx_valid), .rx_byte(a_rx_byte),
        .blk_out_data(a_blk_out_data), .blk_out_valid(a_blk_out_valid), .blk_out_ready(a_blk_out_ready),
        .blk_in_data(a_blk_in_data), .blk_in_valid(a_blk_in_valid), .blk_in_ready(a_blk_in_ready),
        .tx_start(a_tx_start), .tx_dv(a_tx_dv), .tx_byte(a_tx_byte), .tx_done(a_tx_done),
        .rx_count(a_rx_count), .rx_overrun(a_rx_overrun), .rx_timeout(a_rx_timeout), .tx_busy(a_tx_busy)
    );

    uart_block_bridge #(.BLOCK_BYTES(BB), .GAP_CYCLES(0), .TIMEOUT_CYCLES(0), .AUTO_TX(1)) dut_b (
        .clock(clock), .reset(reset), .rx_valid(b_rx_valid), .rx_byte(b_rx_byte),
        .blk_out_data(b_blk_out_data), .blk_out_valid(b_blk_out_valid), .blk_out_ready(b_blk_out_ready),
        .blk_in_data(b_blk_in_data), .blk_in_valid(b_blk_in_valid), .blk_in_ready(b_blk_in_ready),
        .tx_start(b_tx_start), .tx_dv(b_tx_dv), .tx_byte(b_tx_byte), .tx_done(b_tx_done),
        .rx_count(b_rx_count), .rx_overrun(b_rx_overrun), .rx_timeout(b_rx_timeout), .tx_busy(b_tx_busy)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic a_rx(input logic [7:0] b);
        a_rx_valid = 1'b1; a_rx_byte = b;
        tick();
        a_rx_valid = 1'b0;
    endtask

    task automatic b_rx(input logic [7:0] b);
        b_rx_valid = 1'b1; b_rx_byte = b;
        tick();
        b_rx_valid = 1'b0;
    endtask

    // Counts idle cycles after the tx_done-sampling edge until tx_dv shows up.
    task automatic wait_dv(input bit sel_b, input string tag, input int exp_idle);
        int n = 0;
        while (!(sel_b ? b_tx_dv : a_tx_dv) && n < 40) begin
            tick();
            n++;
        end
        chk(tag, 64'(n), 64'(exp_idle));
    endtask

    // Entered with tx_dv just observed high; finishes the byte and waits for the next one.
    task automatic tx_cycle(input bit sel_b, input logic [7:0] exp_byte, input bit last, input int gap);
        chk("tx_byte", sel_b ? b_tx_byte : a_tx_byte, exp_byte);
        tick();
        chk("tx_dv_one_cycle", sel_b ? b_tx_dv : a_tx_dv, 1'b0);
        tick(); tick();
        chk("tx_byte_hold", sel_b ? b_tx_byte : a_tx_byte, exp_byte);
        if (sel_b) b_tx_done = 1'b1; else a_tx_done = 1'b1;
        tick();
        b_tx_done = 1'b0; a_tx_done = 1'b0;
        if (last) begin
            chk("blk_in_ready_after_last", sel_b ? b_blk_in_ready : a_blk_in_ready, 1'b1);
            chk("tx_busy_after_last", sel_b ? b_tx_busy : a_tx_busy, 1'b0);
        end else begin
            wait_dv(sel_b, "gap_idle_cycles", gap);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit stable;
        bit saw_dv;

        tick(); tick();
        chk("rst_tx_dv", a_tx_dv, 1'b0);
        chk("rst_tx_busy", a_tx_busy, 1'b0);
        chk("rst_blk_out_valid", a_blk_out_valid, 1'b0);
        chk("rst_rx_count", a_rx_count, '0);
        chk("rst_blk_out_data", a_blk_out_data, '0);
        chk("rst_tx_byte", a_tx_byte, '0);
        chk("rst_overrun", a_rx_overrun, 1'b0);
        reset = 1'b0;
        tick();

        // ---- RX assembly, overrun, accept-with-byte
        a_rx(8'h11); a_rx(8'h22); a_rx(8'h33);
        chk("rx_count_3", a_rx_count, 3'd3);
        chk("no_valid_at_3", a_blk_out_valid, 1'b0);
        a_rx(8'h44);
        chk("blk_valid_after_4th", a_blk_out_valid, 1'b1);
        chk("rx_count_full", a_rx_count, 3'd4);
        chk("blk_data", a_blk_out_data, 32'h11223344);
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin a_rx_valid = 1'b1; a_rx_byte = 8'h55; end
            tick();
            a_rx_valid = 1'b0;
            if (i == 3) chk("overrun_pulse", a_rx_overrun, 1'b1);
            if (i == 4) chk("overrun_one_cycle", a_rx_overrun, 1'b0);
            if (a_blk_out_data !== 32'h11223344 || a_blk_out_valid !== 1'b1) stable = 1'b0;
        end
        chk("hand_hold_stable", stable, 1'b1);
        a_blk_out_ready = 1'b1; a_rx_valid = 1'b1; a_rx_byte = 8'h66;
        tick();
        a_blk_out_ready = 1'b0; a_rx_valid = 1'b0;
        chk("accept_valid_low", a_blk_out_valid, 1'b0);
        chk("accept_with_byte_count", a_rx_count, 3'd1);
        chk("accept_no_overrun", a_rx_overrun, 1'b0);

        // ---- timeout: a byte in the expiry cycle wins, then real expiry
        repeat (49) tick();
        chk("pre_expiry_count", a_rx_count, 3'd1);
        a_rx(8'h77);
        chk("expiry_race_count", a_rx_count, 3'd2);
        chk("expiry_race_no_to", a_rx_timeout, 1'b0);
        repeat (49) tick();
        chk("to_not_yet", a_rx_timeout, 1'b0);
        chk("to_not_yet_count", a_rx_count, 3'd2);
        tick();
        chk("to_pulse", a_rx_timeout, 1'b1);
        chk("to_count_cleared", a_rx_count, 3'd0);
        tick();
        chk("to_one_cycle", a_rx_timeout, 1'b0);
        a_rx(8'hA0); a_rx(8'hA1); a_rx(8'hA2); a_rx(8'hA3);
        chk("clean_block_valid", a_blk_out_valid, 1'b1);
        chk("clean_block_data", a_blk_out_data, 32'hA0A1A2A3);
        a_blk_out_ready = 1'b1;
        tick();
        a_blk_out_ready = 1'b0;
        chk("clean_accept_count", a_rx_count, 3'd0);

        // ---- manual TX with gap of 5
        a_blk_in_data = 32'hA1B2C3D4; a_blk_in_valid = 1'b1;
        tick();
        a_blk_in_valid = 1'b0;
        chk("armed_ready_low", a_blk_in_ready, 1'b0);
        chk("armed_busy", a_tx_busy, 1'b1);
        saw_dv = 1'b0;
        for (int i = 0; i < 6; i++) begin
            a_tx_done = (i == 2);
            tick();
            if (a_tx_dv) saw_dv = 1'b1;
        end
        a_tx_done = 1'b0;
        chk("no_dv_before_start", saw_dv, 1'b0);
        chk("armed_ignores_done", a_blk_in_ready, 1'b0);
        a_tx_start = 1'b1;
        tick();
        a_tx_start = 1'b0;
        chk("dv_1_after_start", a_tx_dv, 1'b1);
        tx_cycle(1'b0, 8'hA1, 1'b0, 5);
        tx_cycle(1'b0, 8'hB2, 1'b0, 5);
        tx_cycle(1'b0, 8'hC3, 1'b0, 5);
        tx_cycle(1'b0, 8'hD4, 1'b1, 5);

        // ---- auto TX, back-to-back
        b_tx_start = 1'b1;
        tick();
        b_tx_start = 1'b0;
        chk("auto_start_ignored", b_tx_busy, 1'b0);
        b_blk_in_data = 32'h0F1E2D3C; b_blk_in_valid = 1'b1;
        tick();
        b_blk_in_valid = 1'b0;
        chk("auto_no_dv_at_1", b_tx_dv, 1'b0);
        tick();
        chk("auto_dv_at_2", b_tx_dv, 1'b1);
        tx_cycle(1'b1, 8'h0F, 1'b0, 0);
        tx_cycle(1'b1, 8'h1E, 1'b0, 0);
        tx_cycle(1'b1, 8'h2D, 1'b0, 0);
        tx_cycle(1'b1, 8'h3C, 1'b1, 0);

        // ---- reset during SEND of byte 2 with a block pending on RX
        b_rx(8'h01); b_rx(8'h02); b_rx(8'h03); b_rx(8'h04);
        chk("b_blk_valid", b_blk_out_valid, 1'b1);
        chk("b_blk_data", b_blk_out_data, 32'h01020304);
        b_blk_in_data = 32'hCAFEBABE; b_blk_in_valid = 1'b1;
        tick();
        b_blk_in_valid = 1'b0;
        tick();
        chk("b_first_byte", b_tx_byte, 8'hCA);
        b_tx_done = 1'b1;
        tick();
        b_tx_done = 1'b0;
        chk("b_second_dv", b_tx_dv, 1'b1);
        chk("b_second_byte", b_tx_byte, 8'hFE);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_tx_dv", b_tx_dv, 1'b0);
        chk("async_rst_busy", b_tx_busy, 1'b0);
        chk("async_rst_blk_valid", b_blk_out_valid, 1'b0);
        tick();
        reset = 1'b0;
        tick();
        chk("post_rst_ready", b_blk_in_ready, 1'b1);
        chk("post_rst_count", b_rx_count, 3'd0);
        chk("post_rst_flags", {b_rx_overrun, b_rx_timeout}, 2'b00);
        b_blk_in_data = 32'h5A6B7C8D; b_blk_in_valid = 1'b1;
        tick();
        b_blk_in_valid = 1'b0;
        tick();
        chk("fresh_dv", b_tx_dv, 1'b1);
        chk("fresh_byte0", b_tx_byte, 8'h5A);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
